// File: rtl/fs_nand.sv
// Single-bit full subtractor (a - b - c) built from nine 2-input NAND cells, with registered outputs.
// Optional NAND-vs-behavioural self-check is compiled in when FS_NAND_CHECK_EN is defined.

module fs_nand_cell (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

module fs_nand (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic diff,
  output logic bo,
  output logic diff_q,
  output logic bo_q,
  output logic chk_err
);

  logic n1, n2, n3, x, n5, n6, n7;
  logic diff_d, bo_d;

  // First half-subtractor: x = a ^ b, n3 carries the ~a & b term
  fs_nand_cell u_n1 (.a(a),  .b(b),  .y(n1));
  fs_nand_cell u_n2 (.a(a),  .b(n1), .y(n2));
  fs_nand_cell u_n3 (.a(b),  .b(n1), .y(n3));
  fs_nand_cell u_n4 (.a(n2), .b(n3), .y(x));

  // Second half-subtractor against borrow-in; n7 carries the ~x & c term
  fs_nand_cell u_n5 (.a(x),  .b(c),  .y(n5));
  fs_nand_cell u_n6 (.a(x),  .b(n5), .y(n6));
  fs_nand_cell u_n7 (.a(c),  .b(n5), .y(n7));
  fs_nand_cell u_n8 (.a(n6), .b(n7), .y(diff));
  fs_nand_cell u_n9 (.a(n3), .b(n7), .y(bo));

  always_comb begin
    diff_d = diff;
    bo_d   = bo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q <= 1'b0;
      bo_q   <= 1'b0;
    end else begin
      diff_q <= diff_d;
      bo_q   <= bo_d;
    end
  end

`ifdef FS_NAND_CHECK_EN
  logic ref_diff, ref_bo, mismatch;
  logic chk_err_q, chk_err_d;

  // Behavioural reference; any disagreement latches the sticky error
  always_comb begin
    ref_diff  = a ^ b ^ c;
    ref_bo    = (~a & b) | (~(a ^ b) & c);
    mismatch  = (ref_diff != diff) || (ref_bo != bo);
    chk_err_d = chk_err_q | mismatch;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chk_err_q <= 1'b0;
    else     chk_err_q <= chk_err_d;
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && mismatch)
      $display("fs_nand check: NAND network disagrees for a=%b b=%b c=%b", a, b, c);
  end
`endif

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_fs_nand.sv
// Directed self-checking bench for fs_nand: truth-table sweep, registered path, async reset.
// Checker-specific steps run only when FS_NAND_CHECK_EN is defined.

module tb_fs_nand;

  logic clk = 1'b0;
  logic rst, a, b, c;
  logic diff, bo, diff_q, bo_q, chk_err;

  int checks = 0;
  int errors = 0;

  // Truth table indexed by {a,b,c}
  logic [7:0] exp_diff_tbl;
  logic [7:0] exp_bo_tbl;

  fs_nand dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .c      (c),
    .diff   (diff),
    .bo     (bo),
    .diff_q (diff_q),
    .bo_q   (bo_q),
    .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [2:0] v);
    {a, b, c} = v;
  endtask

  initial begin
    logic [2:0] v;
    logic ed, eb;
    exp_diff_tbl = 8'b1001_0110;
    exp_bo_tbl   = 8'b1000_1110;

    rst = 1'b1;
    apply(3'b000);
    #1;
    check("reset_diff_q", diff_q, 1'b0);
    check("reset_bo_q", bo_q, 1'b0);
    check("reset_chk_err", chk_err, 1'b0);

    // Combinational path alive during reset, registers held
    apply(3'b101);
    #1;
    check("rst_comb_diff_101", diff, 1'b0);
    check("rst_comb_bo_101", bo, 1'b0);
    @(posedge clk); #1;
    check("rst_hold_diff_q", diff_q, 1'b0);
    check("rst_hold_bo_q", bo_q, 1'b0);
    apply(3'b001);
    #1;
    check("rst_comb_diff_001", diff, 1'b1);
    check("rst_comb_bo_001", bo, 1'b1);

    // Exhaustive sweep out of reset
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      apply(v);
      ed = exp_diff_tbl[v];
      eb = exp_bo_tbl[v];
      #1;
      check($sformatf("sweep_diff_%03b", v), diff, ed);
      check($sformatf("sweep_bo_%03b", v), bo, eb);
      @(posedge clk); #1;
      check($sformatf("sweep_diff_q_%03b", v), diff_q, ed);
      check($sformatf("sweep_bo_q_%03b", v), bo_q, eb);
      check($sformatf("sweep_chk_err_%03b", v), chk_err, 1'b0);
      @(negedge clk);
    end

    // Registered path latency after reset release
    rst = 1'b1;
    #1;
    check("rst_again_diff_q", diff_q, 1'b0);
    check("rst_again_bo_q", bo_q, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    apply(3'b011);
    #1;
    check("pre_edge_diff_q", diff_q, 1'b0);
    check("pre_edge_bo_q", bo_q, 1'b0);
    @(posedge clk); #1;
    check("lat_diff_q_011", diff_q, 1'b0);
    check("lat_bo_q_011", bo_q, 1'b1);

    // Async reset mid-cycle
    @(negedge clk);
    apply(3'b010);
    @(posedge clk); #1;
    check("pre_async_diff_q", diff_q, 1'b1);
    check("pre_async_bo_q", bo_q, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_diff_q", diff_q, 1'b0);
    check("async_bo_q", bo_q, 1'b0);
    check("async_chk_err", chk_err, 1'b0);
    check("async_comb_diff", diff, 1'b1);
    check("async_comb_bo", bo, 1'b1);
    @(negedge clk);
    rst = 1'b0;

`ifdef FS_NAND_CHECK_EN
    // Fault injection on n7 with 001 must latch the sticky error
    apply(3'b001);
    force dut.n7 = 1'b1;
    #1;
    check("fault_comb_diff", diff, 1'b0);
    @(posedge clk); #1;
    check("fault_chk_err", chk_err, 1'b1);
    @(negedge clk);
    release dut.n7;
    apply(3'b000);
    @(posedge clk); #1;
    check("fault_sticky", chk_err, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("fault_cleared", chk_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
`else
    @(posedge clk); #1;
    check("chk_err_tied", chk_err, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
